// File: rtl/sample_queue.sv
// Dual-channel circular sample buffer that replays the newest TAPS samples
// oldest-first, one per clock, with `sequencing` high across each replay.
module sample_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  parameter int TAPS  = 1021
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [WIDTH-1:0] lft_in,
  input  logic [WIDTH-1:0] rght_in,
  output logic [WIDTH-1:0] lft_out,
  output logic [WIDTH-1:0] rght_out,
  output logic             sequencing
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] TAPS_C  = CW'(TAPS);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] TAPS_A  = AW'(TAPS);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    IDLE = 2'd1,
    READ = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  idx_q, idx_d;
  logic           pending_q, pending_d;
  logic           seq_q, seq_d;
  logic           start_s;
  logic           rd_en_s;
  logic [AW-1:0]  rd_addr_s;
  logic [WIDTH-1:0] lft_out_q, rght_out_q;

  logic [WIDTH-1:0] mem_l [DEPTH];
  logic [WIDTH-1:0] mem_r [DEPTH];

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (valid && (count_d >= TAPS_C)) state_d = READ;
        else                              state_d = FILL;
      end
      IDLE: begin
        if (valid) state_d = READ;
        else       state_d = IDLE;
      end
      READ: begin
        if (idx_q == TAPS_C) state_d = GAP;
        else                 state_d = READ;
      end
      GAP: begin
        if (pending_q) state_d = READ;
        else           state_d = IDLE;
      end
      default: state_d = FILL;
    endcase
  end

  // output logic
  always_comb begin
    seq_d = 1'b0;
    if (state_d == READ) seq_d = 1'b1;
    else                 seq_d = 1'b0;
  end

  // pointer, fill-level, replay index and pending-replay bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (valid) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (count_q != DEPTH_C) count_d = count_q + CW'(1);
      else                    count_d = count_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    // window start uses the post-increment write pointer so it ends on the newest sample
    start_s  = (state_d == READ) && (state_q != READ);
    rd_ptr_d = rd_ptr_q;
    idx_d    = idx_q;
    if (start_s) begin
      rd_ptr_d = wr_ptr_d - TAPS_A;
      idx_d    = '0;
    end else if ((state_q == READ) && (idx_q != TAPS_C)) begin
      idx_d = idx_q + CW'(1);
    end else begin
      idx_d = idx_q;
    end

    pending_d = pending_q;
    if (valid && ((state_q == READ) || ((state_q == GAP) && pending_q))) pending_d = 1'b1;
    else if (state_q == GAP)                                             pending_d = 1'b0;
    else                                                                 pending_d = pending_q;

    rd_en_s   = (state_q == READ) && (idx_q < TAPS_C);
    rd_addr_s = rd_ptr_q + idx_q[AW-1:0];
  end

  // control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      seq_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      seq_q     <= seq_d;
    end
  end

  // sample storage, not reset
  always_ff @(posedge clk) begin
    if (valid) begin
      mem_l[wr_ptr_q] <= lft_in;
      mem_r[wr_ptr_q] <= rght_in;
    end
  end

  // synchronous read port doubles as the gated output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_out_q  <= '0;
      rght_out_q <= '0;
    end else if (rd_en_s) begin
      lft_out_q  <= mem_l[rd_addr_s];
      rght_out_q <= mem_r[rd_addr_s];
    end else begin
      lft_out_q  <= '0;
      rght_out_q <= '0;
    end
  end

  assign lft_out    = lft_out_q;
  assign rght_out   = rght_out_q;
  assign sequencing = seq_q;

endmodule

// File: tb/tb_sample_queue.sv
// Directed bench for sample_queue: fill, wrap-around, pending replays,
// channel independence and reset during a replay.
module tb_sample_queue;

  localparam int WIDTH = 16;
  localparam int DEPTH = 1024;
  localparam int TAPS  = 1021;

  logic             clk;
  logic             rst_n;
  logic             valid;
  logic [WIDTH-1:0] lft_in;
  logic [WIDTH-1:0] rght_in;
  logic [WIDTH-1:0] lft_out;
  logic [WIDTH-1:0] rght_out;
  logic             sequencing;

  int n_checks;
  int n_fail;
  int next_val;
  int model[$];

  sample_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAPS(TAPS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      (valid),
    .lft_in     (lft_in),
    .rght_in    (rght_in),
    .lft_out    (lft_out),
    .rght_out   (rght_out),
    .sequencing (sequencing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // drive the next sample (left = n, right = -n) for the current cycle
  task automatic drive_sample();
    valid   = 1'b1;
    lft_in  = 16'(next_val);
    rght_in = 16'(-next_val);
    model.push_back(next_val);
    next_val++;
  endtask

  // one strobe; returns at the negedge of the cycle after it was sampled
  task automatic strobe();
    @(negedge clk);
    drive_sample();
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk_eq(tag, {31'd0, sequencing}, 32'd0);
      chk_eq(tag, {lft_out, rght_out}, 32'd0);
    end
  endtask

  // fill with TAPS-1 silent strobes, then the triggering strobe
  task automatic fill();
    for (int k = 0; k < TAPS; k++) begin
      @(negedge clk);
      chk_eq("fill_seq", {31'd0, sequencing}, 32'd0);
      chk_eq("fill_out", {lft_out, rght_out}, 32'd0);
      drive_sample();
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  // called at the negedge of the first READ cycle; checks the whole window and the gap
  task automatic check_replay(input int mid_a, input int mid_b, input int rst_at);
    int win[TAPS];
    int base;
    base = model.size() - TAPS;
    for (int k = 0; k < TAPS; k++) win[k] = model[base + k];
    chk_eq("seq_rise", {31'd0, sequencing}, 32'd1);
    chk_eq("out_first_zero", {lft_out, rght_out}, 32'd0);
    for (int i = 0; i < TAPS; i++) begin
      @(negedge clk);
      valid = 1'b0;
      chk_eq("seq_high", {31'd0, sequencing}, 32'd1);
      chk_eq("lft_win", {16'd0, lft_out}, {16'd0, 16'(win[i])});
      chk_eq("rght_win", {16'd0, rght_out}, {16'd0, 16'(-win[i])});
      if (i == mid_a || i == mid_b) drive_sample();
      if (i == rst_at) begin
        #1 rst_n = 1'b0;
        #1;
        chk_eq("rst_seq", {31'd0, sequencing}, 32'd0);
        chk_eq("rst_out", {lft_out, rght_out}, 32'd0);
        return;
      end
    end
    @(negedge clk);
    valid = 1'b0;
    chk_eq("gap_seq", {31'd0, sequencing}, 32'd0);
    chk_eq("gap_out", {lft_out, rght_out}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    next_val = 0;
    rst_n    = 1'b0;
    valid    = 1'b0;
    lft_in   = '0;
    rght_in  = '0;

    repeat (3) @(negedge clk);
    chk_eq("reset_seq", {31'd0, sequencing}, 32'd0);
    chk_eq("reset_out", {lft_out, rght_out}, 32'd0);
    rst_n = 1'b1;

    // values 0..1020: first replay after the 1021st strobe
    fill();
    check_replay(-1, -1, -1);
    idle_cycles(20, "idle_after_fill");

    // spaced strobes push the window across the address wrap
    for (int r = 0; r < 5; r++) begin
      strobe();
      check_replay(-1, -1, -1);
      idle_cycles(76, "idle_spaced");
    end

    // one write mid-replay queues exactly one more replay
    strobe();
    check_replay(500, -1, -1);
    @(negedge clk);
    check_replay(-1, -1, -1);
    idle_cycles(30, "idle_after_pending");

    // two writes mid-replay still give a single extra replay ending on the newer one
    strobe();
    check_replay(100, 200, -1);
    @(negedge clk);
    check_replay(-1, -1, -1);
    idle_cycles(1100, "idle_after_double");

    // reset during replay, then a fresh fill
    strobe();
    check_replay(-1, -1, 300);
    @(negedge clk);
    chk_eq("rst_hold_seq", {31'd0, sequencing}, 32'd0);
    rst_n = 1'b1;
    model.delete();
    fill();
    check_replay(-1, -1, -1);
    idle_cycles(10, "idle_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
